cpu_gen2: RTL and testbench
===========================

// Module: cpu_gen2
// PURPOSE
//  Parametrised successor of the 4-bit two-register CPU: data width and program-address width are generic,
//  jumps (JMP/JNC) are added, and instruction fetch uses a req/valid handshake to an external program memory.
//  Two-state FSM (FETCH/EXECUTE); sits between program ROM/switch inputs and the LED output register.
// PARAMETERS
//  DATA_W  4  width of A, B, OUT, immediate, switch and led
//  ADDR_W  4  width of instruction pointer / program address
// PORTS
//  clk          in   1           single system clock, rising edge
//  rst          in   1           synchronous, active-high reset
//  instr_req    out  1           fetch request; high only in FETCH
//  instr_addr   out  ADDR_W      program address (= ip)
//  instr_valid  in   1           instr holds the word at instr_addr; sampled only in FETCH
//  instr        in   4+DATA_W    {opcode[3:0], imm[DATA_W-1:0]}
//  switch       in   DATA_W      input port read by IN A / IN B
//  led          out  DATA_W      output register value
//  cf           out  1           carry flag
//  halted       out  1           high in HALT state (tied 0 when CPU_HALT_EN undefined)
// BEHAVIOUR
//  - Reset (any state, any cycle): A=B=OUT=0, cf=0, ip=0, ir=0, state=FETCH; in-flight fetch discarded.
//    Outputs after reset: instr_req=1, instr_addr=0, led=0, cf=0, halted=0.
//  - FETCH: instr_req=1; if instr_valid, ir<=instr, go EXECUTE; else hold (no limit on wait).
//  - EXECUTE: instr_req=0, instr_valid ignored; commit instruction in ir, update ip, go FETCH.
//    Minimum 2 cycles/instruction; register/led update visible the cycle after EXECUTE.
//  - Opcodes (cf<=0 for every instruction except ADD):
//    0 ADD A,imm {cf,A}<=A+imm | 1 MOV A,B A<=B | 2 IN A A<=switch | 3 MOV A,imm
//    4 MOV B,A B<=A | 5 ADD B,imm {cf,B}<=B+imm | 6 IN B | 7 MOV B,imm
//    9 OUT B OUT<=B | 11 OUT imm | 14 JNC: ip<=imm if cf==0 else ip+1 | 15 JMP ip<=imm
//    8,10,12,13: NOP (ip+1, cf<=0).
//  - ADD: DATA_W+1-bit sum, carry-out to cf, result modulo 2^DATA_W.
//  - JNC tests cf as held before the JNC (set by preceding ADD); JNC then clears cf.
//  - Jump target: imm zero-extended (ADDR_W>DATA_W) or truncated to low ADDR_W bits (ADDR_W<DATA_W).
//  - ip increment wraps 2^ADDR_W-1 -> 0; no fault.
//  - Unaffected registers hold their value every cycle.
// CONFIGURATION
//  - CPU_HALT_EN defined: opcode 13 = HALT; EXECUTE -> HALT state; halted=1, instr_req=0,
//    all registers and ip frozen (ip points past HALT); exit only by rst.
//  - CPU_HALT_EN undefined: opcode 13 is NOP, HALT state absent, halted tied 0.
// STRUCTURE
//  - Package cpu_gen2_pkg: opcode_t enum (4-bit, names above), state_t enum {FETCH, EXECUTE, HALT}.
//  - Sub-module dffn #(W): W-bit register with sync active-high reset to 0 and load enable;
//    instantiated for A, B, OUT, ip, ir; cf and state are plain flops in cpu_gen2.
// TESTING
//  - rst high 3 cycles mid-EXECUTE of MOV A,5 -> A=0, ip=0, instr_req=1, addr=0, led=0 next cycle.
//  - DATA_W=4: MOV A,14; ADD A,3 -> A=1, cf=1; following MOV B,2 -> cf=0.
//  - ADD A,15 (A=1, cf=1) then JNC 9 -> ip=ip+1; repeat with A=0 (cf=0) -> ip=9.
//  - instr_valid held low 5 cycles in FETCH -> state, ip, registers unchanged; instr_req stays 1.
//  - ADDR_W=4: ip=15 executes NOP -> ip=0; JMP imm=6 from any address -> instr_addr=6.
//  - CPU_HALT_EN: IN B(switch=0xA); OUT B; HALT -> led=0xA, halted=1, instr_req=0 forever until rst.

Source files
------------

// File: rtl/cpu_gen2_pkg.sv
// Shared types for cpu_gen2: opcode encoding and FSM states.
// The HALT opcode is only decoded when CPU_HALT_EN is defined.
package cpu_gen2_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'd0,
        OP_MOV_AB = 4'd1,
        OP_IN_A   = 4'd2,
        OP_MOV_AI = 4'd3,
        OP_MOV_BA = 4'd4,
        OP_ADD_B  = 4'd5,
        OP_IN_B   = 4'd6,
        OP_MOV_BI = 4'd7,
        OP_NOP8   = 4'd8,
        OP_OUT_B  = 4'd9,
        OP_NOP10  = 4'd10,
        OP_OUT_I  = 4'd11,
        OP_NOP12  = 4'd12,
        OP_HALT   = 4'd13,
        OP_JNC    = 4'd14,
        OP_JMP    = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXECUTE = 2'd1,
        HALT    = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_gen2_if.sv
// Bus between cpu_gen2 and its environment: instruction fetch handshake,
// switch input and the led/flag outputs.
interface cpu_gen2_if
    import cpu_gen2_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
);
    logic                    instr_req;
    logic [ADDR_W-1:0]       instr_addr;
    logic                    instr_valid;
    logic [OPC_W+DATA_W-1:0] instr;
    logic [DATA_W-1:0]       switch;
    logic [DATA_W-1:0]       led;
    logic                    cf;
    logic                    halted;

    modport master (
        output instr_req, instr_addr, led, cf, halted,
        input  instr_valid, instr, switch
    );

    modport slave (
        input  instr_req, instr_addr, led, cf, halted,
        output instr_valid, instr, switch
    );
endinterface

// File: rtl/cpu_gen2_dffn.sv
// dffn: W-bit register with synchronous active-high reset to zero and a
// load enable; used for every wide architectural register of cpu_gen2.
module dffn #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            r_q <= '0;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/cpu_gen2.sv
// cpu_gen2: two-register CPU with req/valid fetch, FETCH/EXECUTE FSM and jumps.
// Optional feature macro: CPU_HALT_EN (opcode 13 = HALT, adds HALT state).
module cpu_gen2
    import cpu_gen2_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    cpu_gen2_if.master bus
);
    localparam int IR_W = OPC_W + DATA_W;

    state_t              r_state, w_state_next;
    logic                r_cf, w_cf_next;
    logic                w_req;

    logic [DATA_W-1:0]   w_a, w_b, w_out;
    logic [DATA_W-1:0]   w_a_d, w_b_d, w_out_d;
    logic                w_a_en, w_b_en, w_out_en;
    logic [ADDR_W-1:0]   w_ip, w_ip_d, w_target;
    logic                w_ip_en;
    logic [IR_W-1:0]     w_ir;
    logic                w_ir_en;

    opcode_t             w_op;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W:0]     w_sum_a, w_sum_b;

    assign w_op    = opcode_t'(w_ir[IR_W-1:DATA_W]);
    assign w_imm   = w_ir[DATA_W-1:0];
    assign w_sum_a = {1'b0, w_a} + {1'b0, w_imm};
    assign w_sum_b = {1'b0, w_b} + {1'b0, w_imm};

    // Jump target: immediate zero-extended or truncated to the ip width.
    generate
        if (ADDR_W > DATA_W) begin : g_tgt_ext
            assign w_target = {{(ADDR_W-DATA_W){1'b0}}, w_imm};
        end else begin : g_tgt_trunc
            assign w_target = w_imm[ADDR_W-1:0];
        end
    endgenerate

    dffn #(.W(DATA_W)) u_a   (.clk(clk), .rst(rst), .i_en(w_a_en),   .i_d(w_a_d),      .o_q(w_a));
    dffn #(.W(DATA_W)) u_b   (.clk(clk), .rst(rst), .i_en(w_b_en),   .i_d(w_b_d),      .o_q(w_b));
    dffn #(.W(DATA_W)) u_out (.clk(clk), .rst(rst), .i_en(w_out_en), .i_d(w_out_d),    .o_q(w_out));
    dffn #(.W(ADDR_W)) u_ip  (.clk(clk), .rst(rst), .i_en(w_ip_en),  .i_d(w_ip_d),     .o_q(w_ip));
    dffn #(.W(IR_W))   u_ir  (.clk(clk), .rst(rst), .i_en(w_ir_en),  .i_d(bus.instr),  .o_q(w_ir));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_cf    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cf    <= w_cf_next;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cf_next    = r_cf;
        w_req        = 1'b0;
        w_ir_en      = 1'b0;
        w_a_en       = 1'b0;
        w_b_en       = 1'b0;
        w_out_en     = 1'b0;
        w_ip_en      = 1'b0;
        w_a_d        = w_a;
        w_b_d        = w_b;
        w_out_d      = w_out;
        w_ip_d       = w_ip + ADDR_W'(1);

        case (r_state)
            FETCH: begin
                w_req = 1'b1;
                if (bus.instr_valid) begin
                    w_ir_en      = 1'b1;
                    w_state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                w_state_next = FETCH;
                w_ip_en      = 1'b1;
                w_cf_next    = 1'b0;
                case (w_op)
                    OP_ADD_A:  begin w_a_en = 1'b1; w_a_d = w_sum_a[DATA_W-1:0]; w_cf_next = w_sum_a[DATA_W]; end
                    OP_MOV_AB: begin w_a_en = 1'b1; w_a_d = w_b;        end
                    OP_IN_A:   begin w_a_en = 1'b1; w_a_d = bus.switch; end
                    OP_MOV_AI: begin w_a_en = 1'b1; w_a_d = w_imm;      end
                    OP_MOV_BA: begin w_b_en = 1'b1; w_b_d = w_a;        end
                    OP_ADD_B:  begin w_b_en = 1'b1; w_b_d = w_sum_b[DATA_W-1:0]; w_cf_next = w_sum_b[DATA_W]; end
                    OP_IN_B:   begin w_b_en = 1'b1; w_b_d = bus.switch; end
                    OP_MOV_BI: begin w_b_en = 1'b1; w_b_d = w_imm;      end
                    OP_OUT_B:  begin w_out_en = 1'b1; w_out_d = w_b;    end
                    OP_OUT_I:  begin w_out_en = 1'b1; w_out_d = w_imm;  end
                    // JNC looks at the flag left by the previous instruction.
                    OP_JNC:    if (!r_cf) w_ip_d = w_target;
                    OP_JMP:    w_ip_d = w_target;
`ifdef CPU_HALT_EN
                    OP_HALT:   w_state_next = HALT;
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.instr_req  = w_req;
    assign bus.instr_addr = w_ip;
    assign bus.led        = w_out;
    assign bus.cf         = r_cf;
`ifdef CPU_HALT_EN
    assign bus.halted     = (r_state == HALT);
`else
    assign bus.halted     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_gen2.sv
// Directed self-checking bench for cpu_gen2 (DATA_W=4, ADDR_W=4); the HALT
// sequence is exercised when CPU_HALT_EN is defined.
module tb_cpu_gen2;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    cpu_gen2_if #(.DATA_W(4), .ADDR_W(4)) bus ();

    cpu_gen2 #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full instruction: wait for the request, present the word for one
    // cycle, then let EXECUTE commit. Returns on a negedge back in FETCH.
    task automatic exec(input logic [7:0] word);
        int n = 0;
        while (!bus.instr_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_req) check("fetch_timeout", 32'(bus.instr_req), 32'd1);
        bus.instr       = word;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr       = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 8'h00;
        bus.switch      = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_req",    32'(bus.instr_req),  32'd1);
        check("rst_addr",   32'(bus.instr_addr), 32'd0);
        check("rst_led",    32'(bus.led),        32'd0);
        check("rst_cf",     32'(bus.cf),         32'd0);
        check("rst_halted", 32'(bus.halted),     32'd0);

        // ADD with carry, then a non-ADD clears cf
        exec(8'h3E);                       // MOV A,14
        exec(8'h03);                       // ADD A,3 -> A=1 cf=1
        check("add_cf_set", 32'(bus.cf), 32'd1);
        exec(8'h72);                       // MOV B,2
        check("mov_cf_clr", 32'(bus.cf), 32'd0);
        exec(8'h40);                       // MOV B,A
        exec(8'h90);                       // OUT B
        check("add_result", 32'(bus.led),        32'd1);
        check("ip_seq",     32'(bus.instr_addr), 32'd5);

        // JNC with cf=1 falls through, with cf=0 jumps
        exec(8'h0F);                       // ADD A,15 -> A=0 cf=1, ip=6
        check("add15_cf", 32'(bus.cf), 32'd1);
        exec(8'hE9);                       // JNC 9 not taken
        check("jnc_nt_ip", 32'(bus.instr_addr), 32'd7);
        check("jnc_cf_clr", 32'(bus.cf),        32'd0);
        exec(8'h00);                       // ADD A,0 -> cf=0, ip=8
        exec(8'hE9);                       // JNC 9 taken
        check("jnc_t_ip", 32'(bus.instr_addr), 32'd9);

        // Fetch stall: nothing moves while instr_valid is low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req",  32'(bus.instr_req),  32'd1);
            check("stall_addr", 32'(bus.instr_addr), 32'd9);
        end
        check("stall_led", 32'(bus.led), 32'd1);

        // ip wrap and JMP
        exec(8'h3F);                       // MOV A,15, ip=10
        exec(8'hFE);                       // JMP 14
        check("jmp14", 32'(bus.instr_addr), 32'd14);
        exec(8'h01);                       // ADD A,1 -> A=0 cf=1, ip=15
        check("ip15",  32'(bus.instr_addr), 32'd15);
        check("cf_15", 32'(bus.cf),         32'd1);
        exec(8'hA0);                       // NOP at ip 15
        check("ip_wrap",  32'(bus.instr_addr), 32'd0);
        check("nop_cf",   32'(bus.cf),         32'd0);
        exec(8'hF6);                       // JMP 6
        check("jmp6", 32'(bus.instr_addr), 32'd6);
`ifndef CPU_HALT_EN
        exec(8'hD0);                       // opcode 13 is a NOP here
        check("op13_ip",     32'(bus.instr_addr), 32'd7);
        check("op13_halted", 32'(bus.halted),     32'd0);
        check("op13_req",    32'(bus.instr_req),  32'd1);
`endif

        // Data movement: IN, MOV, OUT imm, ADD B with carry
        bus.switch = 4'hA;
        exec(8'h60);                       // IN B
        exec(8'h90);                       // OUT B
        check("in_b", 32'(bus.led), 32'hA);
        bus.switch = 4'h5;
        exec(8'h20);                       // IN A
        exec(8'h40);                       // MOV B,A
        exec(8'h90);
        check("in_a", 32'(bus.led), 32'h5);
        exec(8'hB3);                       // OUT 3
        check("out_imm", 32'(bus.led), 32'h3);
        exec(8'h77);                       // MOV B,7
        exec(8'h10);                       // MOV A,B -> A=7
        exec(8'h51);                       // ADD B,1 -> B=8
        exec(8'h90);
        check("add_b", 32'(bus.led), 32'h8);
        exec(8'h40);                       // MOV B,A -> B=7
        exec(8'h90);
        check("mov_ab", 32'(bus.led), 32'h7);
        exec(8'h79);                       // MOV B,9
        exec(8'h59);                       // ADD B,9 -> B=2 cf=1
        check("add_b_cf", 32'(bus.cf), 32'd1);
        exec(8'h90);
        check("add_b_mod", 32'(bus.led), 32'h2);
        check("out_cf",    32'(bus.cf),  32'd0);
        exec(8'hC5);                       // NOP 12
        check("nop12_led", 32'(bus.led), 32'h2);

        // Reset asserted while MOV A,5 sits in EXECUTE
        exec(8'h39);                       // MOV A,9
        exec(8'hBF);                       // OUT 15
        check("pre_rst_led", 32'(bus.led), 32'hF);
        bus.instr       = 8'h35;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("mid_rst_req",  32'(bus.instr_req),  32'd1);
        check("mid_rst_addr", 32'(bus.instr_addr), 32'd0);
        check("mid_rst_led",  32'(bus.led),        32'd0);
        exec(8'h40);                       // MOV B,A
        exec(8'h90);                       // OUT B
        check("mid_rst_a", 32'(bus.led), 32'd0);

`ifdef CPU_HALT_EN
        bus.switch = 4'hA;
        exec(8'h60);                       // IN B
        exec(8'h90);                       // OUT B
        exec(8'hD0);                       // HALT at ip 4
        check("halt_led",    32'(bus.led),        32'hA);
        check("halt_flag",   32'(bus.halted),     32'd1);
        check("halt_req",    32'(bus.instr_req),  32'd0);
        check("halt_ip",     32'(bus.instr_addr), 32'd5);
        bus.instr       = 8'hB1;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_hold_req", 32'(bus.instr_req), 32'd0);
            check("halt_hold_led", 32'(bus.led),       32'hA);
        end
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("halt_rst_flag", 32'(bus.halted),    32'd0);
        check("halt_rst_req",  32'(bus.instr_req), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
